ssqa_sched: RTL and testbench

SSQA_SCHED -- requirements
Module: ssqa_sched

---
 rtl/ssqa_sched.sv | 177 +++++++++++++++++
 tb/tb_ssqa_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ssqa_sched.sv
// Scheduler for the SSQA spin-update datapath: clear, multiply-accumulate, read drain, update, iterate.
// Build with SSQA_ANNEAL_EN defined to ramp I0 from i0_min toward i0_max; otherwise I0 is fixed at i0_max.
module ssqa_sched #(
    parameter int N             = 800,
    parameter int NN            = 800,
    parameter int TEM_WIDTH     = 8,
    parameter int READ_LAT      = 2,
    parameter int ANNEAL_PERIOD = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [15:0]                 max_iter,
    input  logic [TEM_WIDTH-1:0]        i0_min,
    input  logic [TEM_WIDTH-1:0]        i0_max,
    input  logic [TEM_WIDTH-1:0]        q_init,
    output logic                        busy,
    output logic                        done,
    output logic                        rst_ini,
    output logic                        en_read,
    output logic                        en_mult,
    output logic                        en_upd,
    output logic                        rst_iter,
    output logic                        wea,
    output logic [$clog2(NN)-1:0]       count_spin,
    output logic [$clog2(NN)-1:0]       count_bit,
    output logic [15:0]                 count_iter,
    output logic signed [TEM_WIDTH-1:0] I0,
    output logic signed [TEM_WIDTH-1:0] Q
);
    localparam int CW = $clog2(NN);
    localparam int DW = $clog2(READ_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, MULT, DRAIN, UPD, ITER, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          spin_q, spin_d, bit_q, bit_d;
    logic [15:0]            iter_q, iter_d, max_q, max_d;
    logic [DW-1:0]          drn_q, drn_d;
    logic [TEM_WIDTH-1:0]   i0_q, i0_d, q_q, q_d;
    logic                   busy_q, done_q, rst_ini_q, en_read_q, en_upd_q, rst_iter_q, wea_q;
    logic [READ_LAT-1:0]    mpipe_q;
`ifdef SSQA_ANNEAL_EN
    logic [TEM_WIDTH-1:0]   i0max_q, i0max_d;
    logic                   step_due;
    assign step_due = ((iter_q + 16'd1) % 16'(ANNEAL_PERIOD)) == 16'd0;
`else
    logic                   unused_cfg;
    assign unused_cfg = ^{i0_min, 16'(ANNEAL_PERIOD)};
`endif

    always_comb begin
        state_d = state_q;
        spin_d  = spin_q;
        bit_d   = bit_q;
        iter_d  = iter_q;
        max_d   = max_q;
        drn_d   = drn_q;
        i0_d    = i0_q;
        q_d     = q_q;
`ifdef SSQA_ANNEAL_EN
        i0max_d = i0max_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    max_d   = (max_iter == 16'd0) ? 16'd1 : max_iter;
                    q_d     = q_init;
                    spin_d  = '0;
                    bit_d   = '0;
                    iter_d  = '0;
`ifdef SSQA_ANNEAL_EN
                    i0_d    = i0_min;
                    i0max_d = i0_max;
`else
                    i0_d    = i0_max;
`endif
                end
            end
            CLEAR: state_d = MULT;
            MULT: begin
                if (bit_q == LAST) begin
                    state_d = DRAIN;
                    bit_d   = '0;
                    drn_d   = '0;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drn_q == DW'(READ_LAT - 1)) state_d = UPD;
                else                            drn_d   = drn_q + 1'b1;
            end
            UPD: begin
                if (spin_q == LAST) begin
                    spin_d  = '0;
                    state_d = ITER;
                end else begin
                    spin_d  = spin_q + 1'b1;
                    state_d = MULT;
                end
            end
            ITER: begin
                iter_d  = iter_q + 16'd1;
                state_d = (iter_q + 16'd1 == max_q) ? DONE : MULT;
`ifdef SSQA_ANNEAL_EN
                // Saturating ramp; an inverted range never steps since i0_min already exceeds the ceiling.
                if (step_due && ($signed(i0_q) < $signed(i0max_q))) i0_d = i0_q + TEM_WIDTH'(1);
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            spin_q     <= '0;
            bit_q      <= '0;
            iter_q     <= '0;
            max_q      <= '0;
            drn_q      <= '0;
            i0_q       <= '0;
            q_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rst_ini_q  <= 1'b0;
            en_read_q  <= 1'b0;
            en_upd_q   <= 1'b0;
            rst_iter_q <= 1'b0;
            wea_q      <= 1'b0;
            mpipe_q    <= '0;
`ifdef SSQA_ANNEAL_EN
            i0max_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            spin_q     <= spin_d;
            bit_q      <= bit_d;
            iter_q     <= iter_d;
            max_q      <= max_d;
            drn_q      <= drn_d;
            i0_q       <= i0_d;
            q_q        <= q_d;
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
            rst_ini_q  <= (state_d == CLEAR);
            en_read_q  <= (state_d == MULT) || (state_d == DRAIN);
            en_upd_q   <= (state_d == UPD);
            rst_iter_q <= (state_d == ITER);
            wea_q      <= (state_d == UPD);
            // Only MULT reads carry operands; DRAIN reads never reach the multiplier strobe.
            mpipe_q[0] <= (state_q == MULT);
            for (int i = 1; i < READ_LAT; i++) mpipe_q[i] <= mpipe_q[i-1];
`ifdef SSQA_ANNEAL_EN
            i0max_q    <= i0max_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rst_ini    = rst_ini_q;
    assign en_read    = en_read_q;
    assign en_mult    = mpipe_q[READ_LAT-1];
    assign en_upd     = en_upd_q;
    assign rst_iter   = rst_iter_q;
    assign wea        = wea_q;
    assign count_spin = spin_q;
    assign count_bit  = bit_q;
    assign count_iter = iter_q;
    assign I0         = i0_q;
    assign Q          = q_q;
endmodule

// File: tb/tb_ssqa_sched.sv
// Bench for ssqa_sched: per-cycle comparison against a loop-built expected trace, plus literal pins.
module tb_ssqa_sched;
    localparam int N = 4, NN = 8, TW = 8, RL = 2, AP = 2;
`ifdef SSQA_ANNEAL_EN
    localparam bit ANN = 1'b1;
`else
    localparam bit ANN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] max_iter = '0;
    logic [TW-1:0] i0_min = '0, i0_max = '0, q_init = '0;
    logic busy, done, rst_ini, en_read, en_mult, en_upd, rst_iter, wea;
    logic [2:0] count_spin, count_bit;
    logic [15:0] count_iter;
    logic signed [TW-1:0] I0, Q;

    ssqa_sched #(.N(N), .NN(NN), .TEM_WIDTH(TW), .READ_LAT(RL), .ANNEAL_PERIOD(AP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .max_iter(max_iter),
        .i0_min(i0_min), .i0_max(i0_max), .q_init(q_init),
        .busy(busy), .done(done), .rst_ini(rst_ini), .en_read(en_read), .en_mult(en_mult),
        .en_upd(en_upd), .rst_iter(rst_iter), .wea(wea),
        .count_spin(count_spin), .count_bit(count_bit), .count_iter(count_iter), .I0(I0), .Q(Q)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic busy, done, rst_ini, en_read, en_mult, en_upd, rst_iter, wea;
        logic [2:0] spin, bitc;
        logic [15:0] iter;
        logic [7:0] i0, q;
    } rec_t;

    rec_t expq[$];
    rec_t idle_exp = '0;
    int checks = 0, errors = 0, cyc = 0;
    int n_upd, n_mult, n_riter, n_done;
    int upd_cyc[$];
    logic [7:0] riter_i0[$];

    function automatic rec_t actual();
        return {busy, done, rst_ini, en_read, en_mult, en_upd, rst_iter, wea,
                count_spin, count_bit, count_iter, I0, Q};
    endfunction

    // Expected trace: one CLEAR, then per iteration N spins of N+RL+1 cycles, an ITER, and a final DONE.
    task automatic build_model(input int mi, input logic [7:0] imin, input logic [7:0] imax, input logic [7:0] qv);
        int e;
        logic signed [7:0] cur, mx;
        rec_t r;
        e = (mi == 0) ? 1 : mi;
        cur = ANN ? imin : imax;
        mx = imax;
        r = '0; r.busy = 1; r.rst_ini = 1; r.i0 = cur; r.q = qv;
        expq.push_back(r);
        for (int it = 0; it < e; it++) begin
            for (int s = 0; s < N; s++) begin
                for (int k = 0; k <= N + RL; k++) begin
                    r = '0; r.busy = 1; r.spin = 3'(s); r.iter = 16'(it); r.i0 = cur; r.q = qv;
                    r.en_mult = (k >= RL) && (k < N + RL);
                    if (k < N) begin
                        r.en_read = 1; r.bitc = 3'(k);
                    end else if (k < N + RL) begin
                        r.en_read = 1;
                    end else begin
                        r.en_upd = 1; r.wea = 1;
                    end
                    expq.push_back(r);
                end
            end
            r = '0; r.busy = 1; r.rst_iter = 1; r.iter = 16'(it); r.i0 = cur; r.q = qv;
            expq.push_back(r);
            if (ANN && ((it + 1) % AP == 0) && (cur < mx)) cur = cur + 8'sd1;
        end
        r = '0; r.busy = 1; r.done = 1; r.iter = 16'(e); r.i0 = cur; r.q = qv;
        expq.push_back(r);
        idle_exp = '0; idle_exp.iter = 16'(e); idle_exp.i0 = cur; idle_exp.q = qv;
    endtask

    always @(negedge clk) begin
        rec_t a, e;
        a = actual();
        if (!rst_n) begin
            expq.delete();
            idle_exp = '0;
            e = '0;
        end else if (expq.size() > 0) begin
            e = expq.pop_front();
        end else begin
            e = idle_exp;
        end
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL outputs @cycle %0d: got %h expected %h", cyc, a, e);
        end
        if (en_upd) begin n_upd++; upd_cyc.push_back(cyc); end
        if (en_mult) n_mult++;
        if (rst_iter) begin n_riter++; riter_i0.push_back(I0); end
        if (done) n_done++;
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_upd = 0; n_mult = 0; n_riter = 0; n_done = 0;
        upd_cyc.delete(); riter_i0.delete();
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 4000 && expq.size() > 0; c++) @(posedge clk);
        checks++;
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL run_timeout: %0d expected cycles left, required 0", expq.size());
            expq.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic launch(input int mi, input logic [7:0] imin, input logic [7:0] imax, input logic [7:0] qv);
        @(posedge clk); #1;
        clear_counts();
        max_iter = 16'(mi); i0_min = imin; i0_max = imax; q_init = qv; start = 1'b1;
        @(posedge clk);
        build_model(mi, imin, imax, qv);
        #1 start = 1'b0;
    endtask

    task automatic do_run(input int mi, input logic [7:0] imin, input logic [7:0] imax, input logic [7:0] qv, input int spur);
        launch(mi, imin, imax, qv);
        if (spur > 0) begin
            repeat (spur) @(posedge clk);
            #1 start = 1'b1; max_iter = 16'($urandom_range(0, 5)); q_init = 8'($urandom);
            @(posedge clk); #1 start = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_counts();
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", int'(actual() == '0), 1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single iteration: four updates seven cycles apart, one done.
        do_run(1, 8'd3, 8'd10, 8'd7, 0);
        chk("upd_count_1iter", n_upd, 4);
        chk("mult_count_1iter", n_mult, 16);
        chk("done_count_1iter", n_done, 1);
        for (int i = 1; i < 4; i++) chk("upd_spacing", upd_cyc[i] - upd_cyc[i-1], 7);

        // Three iterations.
        do_run(3, 8'd1, 8'd2, 8'hF0, 0);
        chk("riter_count_3iter", n_riter, 3);
        chk("upd_count_3iter", n_upd, 12);
        chk("mult_count_3iter", n_mult, 48);
        chk("final_count_iter", int'(count_iter), 3);

`ifdef SSQA_ANNEAL_EN
        do_run(6, 8'd5, 8'd6, 8'd9, 0);
        chk("anneal_riter_count", riter_i0.size(), 6);
        chk("anneal_i0_iter2", int'(riter_i0[1]), 5);
        chk("anneal_i0_iter4", int'(riter_i0[3]), 6);
        chk("anneal_i0_iter6", int'(riter_i0[5]), 6);
`else
        do_run(6, 8'd5, 8'd10, 8'd9, 0);
        chk("fixed_riter_count", riter_i0.size(), 6);
        for (int i = 0; i < 6; i++) chk("fixed_i0_at_iter", int'(riter_i0[i]), 10);
`endif

        // max_iter=0 runs one iteration; a start while busy is ignored.
        do_run(0, 8'd2, 8'd4, 8'd1, 10);
        chk("zero_iter_riter", n_riter, 1);
        chk("zero_iter_done", n_done, 1);

        // Asynchronous reset during MULT of spin 2, then a fresh run.
        launch(2, 8'd0, 8'd3, 8'd5);
        repeat (17) @(posedge clk);
        #2;
        chk("pre_reset_spin", int'(count_spin), 2);
        chk("pre_reset_bit", int'(count_bit), 2);
        rst_n = 1'b0;
        #1 chk("async_reset_zero", int'(actual() == '0), 1);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        do_run(1, 8'd0, 8'd3, 8'd5, 0);
        chk("restart_upd_count", n_upd, 4);

        for (int r = 0; r < 8; r++)
            do_run($urandom_range(0, 3), 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 25));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
